multi_pushbutton_processor: RTL and testbench
=============================================

Name: multi_pushbutton_processor

Overview:
- Parametrised, multi-channel successor to the single-button press processor.
- Synchronises, debounces and classifies NUM_BTN independent pushbuttons into single-cycle short-press, long-press and auto-repeat event pulses.
- Runs on the 1 kHz tick clock, so all time parameters are in milliseconds (= cycles).
- Feeds the scoreboard counter/mode logic, replacing per-button count_up/count_down wiring.

Parameters:
NUM_BTN, 4, number of independent button channels (1..16)
DEBOUNCE_MS, 20, consecutive stable cycles required to accept a level change (2..255)
LONG_MS, 2000, debounced hold duration that classifies a press as long (> DEBOUNCE_MS, < 2^16)
REPEAT_MS, 250, auto-repeat period once a long press is recognised (1..2^16-1)

Ports:
clk_1khz  in  1  1 kHz system clock; all logic on the rising edge
rst_i  in  1  synchronous, active-high reset
pushbutton_i  in  NUM_BTN  raw asynchronous, bouncing button levels (1 = pressed)
repeat_en_i  in  1  1 = repeat_o pulses while a long press is held; sampled every cycle
pressed_o  out  NUM_BTN  debounced button level per channel
short_o  out  NUM_BTN  1-cycle pulse: press released before reaching LONG_MS
long_o  out  NUM_BTN  1-cycle pulse: press has been held for LONG_MS
repeat_o  out  NUM_BTN  1-cycle pulse every REPEAT_MS while in the long state with repeat_en_i=1
any_pressed_o  out  1  OR of pressed_o

Behaviour:
- Interface: single clock clk_1khz; rst_i is synchronous and active-high. All outputs are registered.
- Reset (rst_i=1 at a rising edge):
  - All synchroniser flops, pressed_o, counters and outputs go to 0.
  - Every FSM goes to IDLE.
  - Reset mid-press silently aborts the press; no pulse is emitted.
  - A button still held after reset is re-debounced and treated as a new press.
- Per channel, fully independent; no cross-channel interaction.
- Sync: 2-flop synchroniser per channel; sync output lags the pin by 2 cycles.
- Debounce:
  - 8-bit db_cnt.
  - If sync != pressed_o: db_cnt increments. When db_cnt == DEBOUNCE_MS-1, pressed_o toggles and db_cnt clears.
  - If sync == pressed_o: db_cnt clears. Any bounce restarts the window.
  - A clean pin edge therefore reaches pressed_o exactly DEBOUNCE_MS+2 cycles later.
- Press FSM; hold_cnt and rpt_cnt are 16-bit.
  - IDLE: on pressed_o 0->1, go to PRESS with hold_cnt=1.
  - PRESS, pressed_o=1: hold_cnt increments. When hold_cnt == LONG_MS, assert long_o for that cycle, go to LONG, rpt_cnt=0.
  - PRESS, pressed_o=0: assert short_o for 1 cycle, go to IDLE.
  - LONG, pressed_o=1: if repeat_en_i=1, rpt_cnt increments; when rpt_cnt reaches REPEAT_MS, assert repeat_o and clear rpt_cnt. If repeat_en_i=0, rpt_cnt holds at 0 and no repeat_o is produced.
  - LONG, pressed_o=0: go to IDLE with no pulse; release after a long press never produces short_o.
- Event timing:
  - Each event pulse is asserted in the cycle after the pressed_o edge or count match that triggers it.
  - long_o rises exactly LONG_MS cycles after pressed_o rises.
  - The first repeat_o rises REPEAT_MS cycles after long_o.
- Mutual exclusion: at most one of short_o/long_o/repeat_o is high per channel per cycle. Each press yields exactly one short_o or exactly one long_o.
- Simultaneous presses on several channels produce independent, possibly coincident pulses on their own bits.
- Toggling repeat_en_i mid-LONG:
  - 1->0 freezes rpt_cnt at 0.
  - 0->1 starts a fresh REPEAT_MS interval.

Test Plan:
- Reset with pushbutton_i=4'b1111 held: all outputs 0 during reset. After release of rst_i, pressed_o=4'b1111 exactly 22 cycles later; no short_o/long_o during this time.
- Ch0 bounce (1ms high, 2ms low, 2ms high, 1ms low, 2ms high) then stable high 30 ms, then low: exactly one pressed_o[0] rise and exactly one short_o[0] pulse, 23 cycles after the final clean release edge; long_o stays 0.
- Ch1 held 2150 ms, repeat_en_i=0: long_o[1] pulses once, 2000 cycles after pressed_o[1] rises; no repeat_o. Release then produces no short_o[1].
- Ch2 held 2800 ms, repeat_en_i=1: long_o[2] at T, repeat_o[2] at T+250/500/750; no other pulses. After release, FSM is in IDLE.
- Ch0 short press and ch3 long press overlapping in time: each channel's pulses are identical to isolated runs.
- rst_i asserted at 1500 ms into a ch1 hold, released while the button is still held: no long_o at the original 2000 ms. A new long_o occurs 2000 cycles after the re-debounced pressed_o rise.

Source files
------------

// File: rtl/multi_pushbutton_processor.sv
// ---------------------------------------------------------------------------
// multi_pushbutton_processor
//
// Synchronises, debounces and classifies NUM_BTN independent pushbuttons into
// single-cycle short-press, long-press and auto-repeat event pulses. Runs on
// the 1 kHz tick clock, so every time parameter is in milliseconds (= cycles).
//
// Ports:
//   clk_1khz       in   1        1 kHz clock, rising edge
//   rst_i          in   1        synchronous, active-high reset
//   pushbutton_i   in   NUM_BTN  raw bouncing button levels (1 = pressed)
//   repeat_en_i    in   1        enables repeat_o pulses while a long press is held
//   pressed_o      out  NUM_BTN  debounced level per channel
//   short_o        out  NUM_BTN  1-cycle pulse: released before LONG_MS
//   long_o         out  NUM_BTN  1-cycle pulse: held for LONG_MS
//   repeat_o       out  NUM_BTN  1-cycle pulse every REPEAT_MS in the long state
//   any_pressed_o  out  1        OR of pressed_o
//
// Press FSM (one per channel):
//   state | meaning
//   IDLE  | button released, waiting for a debounced press
//   PRESS | held, counting towards LONG_MS; release here gives short_o
//   LONG  | long press recognised; optional auto-repeat, release is silent
// ---------------------------------------------------------------------------
module multi_pushbutton_processor #(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 2000,
    parameter int REPEAT_MS   = 250
) (
    input  logic               clk_1khz,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] pushbutton_i,
    input  logic               repeat_en_i,
    output logic [NUM_BTN-1:0] pressed_o,
    output logic [NUM_BTN-1:0] short_o,
    output logic [NUM_BTN-1:0] long_o,
    output logic [NUM_BTN-1:0] repeat_o,
    output logic               any_pressed_o
);

    localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_MS - 1);
    localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 1);
    localparam logic [15:0] RPT_LAST  = 16'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    logic [NUM_BTN-1:0] sync_a;
    logic [NUM_BTN-1:0] sync_b;
    logic [7:0]         db_cnt     [NUM_BTN];
    logic [7:0]         db_cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0] pressed_nxt;
    state_t             state      [NUM_BTN];
    logic [15:0]        hold_cnt   [NUM_BTN];
    logic [15:0]        rpt_cnt    [NUM_BTN];

    // Debounce next-state: a level change is accepted only after the
    // synchronised input has differed from pressed_o for DEBOUNCE_MS
    // consecutive cycles; any agreement restarts the window.
    always_comb begin
        pressed_nxt = pressed_o;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_nxt[i] = 8'd0;
            if (sync_b[i] != pressed_o[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    pressed_nxt[i] = sync_b[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_1khz) begin
        if (rst_i) begin
            sync_a        <= '0;
            sync_b        <= '0;
            pressed_o     <= '0;
            any_pressed_o <= 1'b0;
            short_o       <= '0;
            long_o        <= '0;
            repeat_o      <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i]   <= 8'd0;
                state[i]    <= IDLE;
                hold_cnt[i] <= 16'd0;
                rpt_cnt[i]  <= 16'd0;
            end
        end else begin
            sync_a        <= pushbutton_i;
            sync_b        <= sync_a;
            pressed_o     <= pressed_nxt;
            // Registered from the next-state vector so it tracks pressed_o
            // in the same cycle.
            any_pressed_o <= |pressed_nxt;
            short_o       <= '0;
            long_o        <= '0;
            repeat_o      <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= db_cnt_nxt[i];
                case (state[i])
                    IDLE: begin
                        // IDLE is only ever entered with pressed_o low, so a
                        // high level here is always a fresh rising edge.
                        if (pressed_o[i]) begin
                            state[i]    <= PRESS;
                            hold_cnt[i] <= 16'd1;
                        end
                    end
                    PRESS: begin
                        if (!pressed_o[i]) begin
                            short_o[i] <= 1'b1;
                            state[i]   <= IDLE;
                        end else if (hold_cnt[i] == LONG_LAST) begin
                            // hold_cnt reaches LONG_MS on this edge, which is
                            // LONG_MS cycles after the pressed_o rise.
                            long_o[i]  <= 1'b1;
                            state[i]   <= LONG;
                            rpt_cnt[i] <= 16'd0;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + 16'd1;
                        end
                    end
                    LONG: begin
                        if (!pressed_o[i]) begin
                            state[i] <= IDLE;
                        end else if (!repeat_en_i) begin
                            rpt_cnt[i] <= 16'd0;
                        end else if (rpt_cnt[i] == RPT_LAST) begin
                            repeat_o[i] <= 1'b1;
                            rpt_cnt[i]  <= 16'd0;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + 16'd1;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_pushbutton_processor.sv
// ---------------------------------------------------------------------------
// tb_multi_pushbutton_processor
//
// Directed scenarios drive the buttons and push the expected events
// (pressed rise/fall, short, long, repeat) with their expected cycle into a
// queue. A monitor on the falling clock edge matches every observed event
// against that queue; unexpected events, wrong cycles and events never seen
// are reported.
// ---------------------------------------------------------------------------
module tb_multi_pushbutton_processor;

    localparam int NB = 4;
    localparam int K_SHORT = 0;
    localparam int K_LONG  = 1;
    localparam int K_RPT   = 2;
    localparam int K_RISE  = 3;
    localparam int K_FALL  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] pb;
    logic          ren;
    logic [NB-1:0] pressed;
    logic [NB-1:0] short_p;
    logic [NB-1:0] long_p;
    logic [NB-1:0] rpt_p;
    logic          any_p;

    multi_pushbutton_processor #(
        .NUM_BTN(NB), .DEBOUNCE_MS(20), .LONG_MS(2000), .REPEAT_MS(250)
    ) dut (
        .clk_1khz     (clk),
        .rst_i        (rst),
        .pushbutton_i (pb),
        .repeat_en_i  (ren),
        .pressed_o    (pressed),
        .short_o      (short_p),
        .long_o       (long_p),
        .repeat_o     (rpt_p),
        .any_pressed_o(any_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int ch;
        int at;
    } ev_t;

    ev_t           exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [NB-1:0] prev_pressed = '0;

    function automatic string kname(int k);
        case (k)
            K_SHORT: return "short_o";
            K_LONG:  return "long_o";
            K_RPT:   return "repeat_o";
            K_RISE:  return "pressed_rise";
            default: return "pressed_fall";
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int ch, input int at);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic match_ev(input int kind, input int ch);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].ch == ch) idx = i;
        n_checks++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL %s[%0d] unexpected: got event at cycle %0d, required none",
                     kname(kind), ch, cyc);
        end else begin
            if (exp_q[idx].at != cyc) begin
                n_fail++;
                $display("FAIL %s[%0d] timing: got cycle %0d, required cycle %0d",
                         kname(kind), ch, cyc, exp_q[idx].at);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every pulse and every pressed_o edge must match an expectation.
    always @(negedge clk) begin
        for (int c = 0; c < NB; c++) begin
            if (short_p[c] === 1'b1) match_ev(K_SHORT, c);
            if (long_p[c] === 1'b1)  match_ev(K_LONG, c);
            if (rpt_p[c] === 1'b1)   match_ev(K_RPT, c);
            if (pressed[c] === 1'b1 && prev_pressed[c] === 1'b0) match_ev(K_RISE, c);
            if (pressed[c] === 1'b0 && prev_pressed[c] === 1'b1) match_ev(K_FALL, c);
        end
        prev_pressed = pressed;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got no end of stimulus, required finish within 60000 cycles");
        $fatal(1);
    end

    initial begin
        int t0;
        int lv[5];
        int dur[5];
        lv  = '{1, 0, 1, 0, 1};
        dur = '{1, 2, 2, 1, 32};

        rst = 1'b1;
        pb  = '0;
        ren = 1'b0;
        tick(2);

        // Buttons held through reset: outputs stay low, then a fresh debounce.
        pb = '1;
        tick(3);
        check("reset_pressed", 32'(pressed), 32'h0);
        check("reset_short",   32'(short_p), 32'h0);
        check("reset_long",    32'(long_p),  32'h0);
        check("reset_repeat",  32'(rpt_p),   32'h0);
        check("reset_any",     32'(any_p),   32'h0);
        tick(2);
        rst = 1'b0;
        t0 = cyc;
        for (int c = 0; c < NB; c++) expect_ev(K_RISE, c, t0 + 22);
        tick(30);
        check("all_pressed", 32'(pressed), 32'hF);
        check("any_pressed_high", 32'(any_p), 32'h1);
        pb = '0;
        t0 = cyc;
        for (int c = 0; c < NB; c++) begin
            expect_ev(K_FALL, c, t0 + 22);
            expect_ev(K_SHORT, c, t0 + 23);
        end
        tick(40);
        check("any_pressed_low", 32'(any_p), 32'h0);

        // Ch0 bounce then clean short press.
        for (int i = 0; i < 5; i++) begin
            pb[0] = lv[i][0];
            if (i == 4) expect_ev(K_RISE, 0, cyc + 22);
            tick(dur[i]);
        end
        pb[0] = 1'b0;
        t0 = cyc;
        expect_ev(K_FALL, 0, t0 + 22);
        expect_ev(K_SHORT, 0, t0 + 23);
        tick(40);

        // Ch1 long press without repeat; silent release.
        ren = 1'b0;
        pb[1] = 1'b1;
        t0 = cyc;
        expect_ev(K_RISE, 1, t0 + 22);
        expect_ev(K_LONG, 1, t0 + 2022);
        tick(2150);
        pb[1] = 1'b0;
        expect_ev(K_FALL, 1, cyc + 22);
        tick(60);

        // Ch2 long press with repeat.
        ren = 1'b1;
        pb[2] = 1'b1;
        t0 = cyc;
        expect_ev(K_RISE, 2, t0 + 22);
        expect_ev(K_LONG, 2, t0 + 2022);
        expect_ev(K_RPT,  2, t0 + 2272);
        expect_ev(K_RPT,  2, t0 + 2522);
        expect_ev(K_RPT,  2, t0 + 2772);
        tick(2800);
        pb[2] = 1'b0;
        expect_ev(K_FALL, 2, cyc + 22);
        tick(40);
        ren = 1'b0;
        // A following short press on ch2 shows the channel went back to IDLE.
        pb[2] = 1'b1;
        expect_ev(K_RISE, 2, cyc + 22);
        tick(50);
        pb[2] = 1'b0;
        t0 = cyc;
        expect_ev(K_FALL, 2, t0 + 22);
        expect_ev(K_SHORT, 2, t0 + 23);
        tick(40);

        // Overlapping ch3 long press and ch0 short press.
        pb[3] = 1'b1;
        t0 = cyc;
        expect_ev(K_RISE, 3, t0 + 22);
        expect_ev(K_LONG, 3, t0 + 2022);
        tick(100);
        pb[0] = 1'b1;
        expect_ev(K_RISE, 0, cyc + 22);
        tick(50);
        pb[0] = 1'b0;
        expect_ev(K_FALL, 0, cyc + 22);
        expect_ev(K_SHORT, 0, cyc + 23);
        tick(1950);
        pb[3] = 1'b0;
        expect_ev(K_FALL, 3, cyc + 22);
        tick(40);

        // Reset 1500 ms into a ch1 hold; button stays held through release.
        pb[1] = 1'b1;
        expect_ev(K_RISE, 1, cyc + 22);
        tick(1500);
        rst = 1'b1;
        expect_ev(K_FALL, 1, cyc + 1);
        tick(5);
        check("midpress_reset_pressed", 32'(pressed), 32'h0);
        check("midpress_reset_any",     32'(any_p),   32'h0);
        rst = 1'b0;
        t0 = cyc;
        expect_ev(K_RISE, 1, t0 + 22);
        expect_ev(K_LONG, 1, t0 + 2022);
        tick(2100);
        pb[1] = 1'b0;
        expect_ev(K_FALL, 1, cyc + 22);
        tick(40);

        check("pending_events", 32'(exp_q.size()), 32'h0);
        foreach (exp_q[i])
            $display("  never seen: %s[%0d] due at cycle %0d",
                     kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].at);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
